// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
//
// Raster timing generator for 640x480 @ 60 Hz VGA, clocked by the 25 MHz
// pixel clock. It produces the raster position consumed by the sprite
// renderers and the sync pulses for the VGA connector.
//
// Ports
//   vga_clk     in   pixel clock; all state changes on its rising edge
//   reset_n     in   asynchronous active-low reset
//   DrawX       out  [9:0] horizontal count, 0..H_TOTAL-1
//   DrawY       out  [9:0] vertical count,   0..V_TOTAL-1
//   blank       out  high while the current position is visible
//   hs          out  horizontal sync, active-low
//   vs          out  vertical sync, active-low
//   frame_start out  one-cycle pulse while the position is (0,0)
//
// Optional feature macro: VGA_SYNC_DELAY_EN
//   Defined   : hs/vs pass through one extra register stage so they line up
//               with sprite colours, which are registered one cycle after
//               DrawX/DrawY.
//   Undefined : hs/vs describe the same position as DrawX/DrawY.
//
// The design has no FSM and no handshake: the counters free-run every cycle.
// All H/V totals must be <= 1024 so the counters fit in 10 bits.
// -----------------------------------------------------------------------------
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start
);

    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0] H_MAX = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX = 10'(V_TOTAL - 1);

    // Decode bounds are 11 bits wide so a sync end equal to 1024 still fits.
    localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
    localparam logic [10:0] HS_START   = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END     = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
    localparam logic [10:0] VS_START   = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END     = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] hc;
    logic [9:0] vc;
    logic [9:0] hc_next;
    logic [9:0] vc_next;

    logic       blank_next;
    logic       hs_next;
    logic       vs_next;
    logic       frame_start_next;

    logic       hs_raw;
    logic       vs_raw;

    // -------------------------------------------------------------------------
    // Next position: hc wraps at the end of every line, vc advances only on
    // the line wrap and itself wraps at the end of the frame.
    // -------------------------------------------------------------------------
    always_comb begin
        hc_next = hc + 10'd1;
        vc_next = vc;
        if (hc == H_MAX) begin
            hc_next = 10'd0;
            if (vc == V_MAX) begin
                vc_next = 10'd0;
            end else begin
                vc_next = vc + 10'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Decode of the *next* position. Registering these alongside the counters
    // makes the decoded flags describe the same position DrawX/DrawY show in
    // that cycle, with no combinational path to the outputs.
    // -------------------------------------------------------------------------
    always_comb begin
        blank_next       = ({1'b0, hc_next} < H_VIS_END) &&
                           ({1'b0, vc_next} < V_VIS_END);
        hs_next          = !(({1'b0, hc_next} >= HS_START) &&
                             ({1'b0, hc_next} <  HS_END));
        vs_next          = !(({1'b0, vc_next} >= VS_START) &&
                             ({1'b0, vc_next} <  VS_END));
        frame_start_next = (hc_next == 10'd0) && (vc_next == 10'd0);
    end

    // -------------------------------------------------------------------------
    // Counter and decode registers. Reset parks the raster at (0,0), which is
    // a visible, non-sync position; frame_start stays low so the frame that
    // begins at reset release is not flagged.
    // -------------------------------------------------------------------------
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc          <= 10'd0;
            vc          <= 10'd0;
            blank       <= 1'b1;
            hs_raw      <= 1'b1;
            vs_raw      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            hc          <= hc_next;
            vc          <= vc_next;
            blank       <= blank_next;
            hs_raw      <= hs_next;
            vs_raw      <= vs_next;
            frame_start <= frame_start_next;
        end
    end

    assign DrawX = hc;
    assign DrawY = vc;

`ifdef VGA_SYNC_DELAY_EN
    // Extra stage keeps the syncs aligned with the registered sprite colour,
    // which lags DrawX/DrawY by one pixel clock.
    logic hs_dly;
    logic vs_dly;

    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_dly <= 1'b1;
            vs_dly <= 1'b1;
        end else begin
            hs_dly <= hs_raw;
            vs_dly <= vs_raw;
        end
    end

    assign hs = hs_dly;
    assign vs = vs_dly;
`else
    assign hs = hs_raw;
    assign vs = vs_raw;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
//
// Directed bench for vga_timing_gen. Two instances share the clock and reset:
//   dut_a : default 640x480 timing (800 x 525), used for reset behaviour,
//           line timing and mid-frame reset.
//   dut_b : shrunken raster (15 x 10 = 150 cycles per frame) so whole-frame
//           behaviour (wrap, vs, frame_start, blank edges) is reachable in a
//           short run.
//             H: visible 8, front 2, sync 3, back 2 -> hs low at x = 10..12
//             V: visible 6, front 1, sync 2, back 1 -> vs low on lines 7..8
//
// Inputs are driven and outputs sampled on the falling edge of vga_clk.
// Position index t counts falling edges after reset release; t=1 is (1,0),
// so position (x,y) of frame f is at t = 150*f + 15*y + x on dut_b.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

`ifdef VGA_SYNC_DELAY_EN
    localparam int SYNC_LAT = 1;
`else
    localparam int SYNC_LAT = 0;
`endif

    // ---------------------------------------------------------------- clock/reset
    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    always #20 vga_clk = ~vga_clk;

    // ---------------------------------------------------------------- DUTs
    logic [9:0] a_dx, a_dy;
    logic       a_blank, a_hs, a_vs, a_fs;
    logic [9:0] b_dx, b_dy;
    logic       b_blank, b_hs, b_vs, b_fs;

    vga_timing_gen dut_a (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (a_dx),
        .DrawY       (a_dy),
        .blank       (a_blank),
        .hs          (a_hs),
        .vs          (a_vs),
        .frame_start (a_fs)
    );

    vga_timing_gen #(
        .H_VISIBLE (8),
        .H_FRONT   (2),
        .H_SYNC    (3),
        .H_BACK    (2),
        .V_VISIBLE (6),
        .V_FRONT   (1),
        .V_SYNC    (2),
        .V_BACK    (1)
    ) dut_b (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (b_dx),
        .DrawY       (b_dy),
        .blank       (b_blank),
        .hs          (b_hs),
        .vs          (b_vs),
        .frame_start (b_fs)
    );

    // ---------------------------------------------------------------- scoreboard
    int errors = 0;
    int checks = 0;

    // Expected t values at which dut_b raises frame_start.
    logic [31:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic tick(input int n = 1);
        repeat (n) @(negedge vga_clk);
    endtask

    task automatic chk_reset_values(input string who);
        chk({who, "_a_dx"},    32'(a_dx),    0);
        chk({who, "_a_dy"},    32'(a_dy),    0);
        chk({who, "_a_blank"}, 32'(a_blank), 1);
        chk({who, "_a_hs"},    32'(a_hs),    1);
        chk({who, "_a_vs"},    32'(a_vs),    1);
        chk({who, "_a_fs"},    32'(a_fs),    0);
        chk({who, "_b_dx"},    32'(b_dx),    0);
        chk({who, "_b_dy"},    32'(b_dy),    0);
        chk({who, "_b_fs"},    32'(b_fs),    0);
    endtask

    // ---------------------------------------------------------------- stimulus
    int   hs_low, blank_hi, hs_first, hs_falls;
    logic prev_hs;
    logic blank_639, blank_640;

    int          vs_low1, vs_low2, blank1, blank2, hs_low2;
    int          vs_first_x, vs_first_y;
    logic [31:0] fs_exp;
    logic [9:0]  wrap_x, wrap_y, next_x, next_y;
    logic        wrap_fs, wrap_blank;
    logic        edge_639_479, edge_640_479, edge_0_480;

    initial begin
        // 1. Reset hold and release.
        reset_n = 1'b0;
        tick(5);
        chk_reset_values("rst_hold");
        reset_n = 1'b1;
        tick();
        chk("rel_a_dx", 32'(a_dx), 1);
        chk("rel_a_dy", 32'(a_dy), 0);
        chk("rel_a_fs", 32'(a_fs), 0);

        // 2. Line timing on the full-size raster: measure line 1 completely.
        tick(799);
        chk("line_wrap_dx", 32'(a_dx), 0);
        chk("line_wrap_dy", 32'(a_dy), 1);
        chk("line_wrap_fs", 32'(a_fs), 0);

        hs_low   = 0;
        blank_hi = 0;
        hs_first = -1;
        hs_falls = 0;
        prev_hs  = a_hs;
        for (int i = 0; i < 800; i++) begin
            if (a_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(a_dx);
            end
            if (prev_hs === 1'b1 && a_hs === 1'b0) hs_falls++;
            if (a_blank === 1'b1) blank_hi++;
            if (a_dx == 10'd639) blank_639 = a_blank;
            if (a_dx == 10'd640) blank_640 = a_blank;
            prev_hs = a_hs;
            tick();
        end
        chk("line_hs_low",    32'(hs_low),   96);
        chk("line_hs_first",  32'(hs_first), 656 + SYNC_LAT);
        chk("line_hs_falls",  32'(hs_falls), 1);
        chk("line_blank_hi",  32'(blank_hi), 640);
        chk("line_blank_639", 32'(blank_639), 1);
        chk("line_blank_640", 32'(blank_640), 0);
        chk("line2_dx",       32'(a_dx), 0);
        chk("line2_dy",       32'(a_dy), 2);

        // 5. Mid-frame reset, asserted between clock edges at (300,2).
        tick(300);
        chk("pre_rst_dx", 32'(a_dx), 300);
        chk("pre_rst_dy", 32'(a_dy), 2);
        #5 reset_n = 1'b0;
        #1 chk_reset_values("mid_rst");
        tick(2);
        reset_n = 1'b1;
        tick();
        chk("mid_rel_a_dx", 32'(a_dx), 1);
        chk("mid_rel_a_dy", 32'(a_dy), 0);

        // 3/4/6. Two frames on the small raster right after the reset release.
        exp_q.push_back(32'd150);
        exp_q.push_back(32'd300);
        vs_low1 = 0; vs_low2 = 0; blank1 = 0; blank2 = 0; hs_low2 = 0;
        vs_first_x = -1; vs_first_y = -1;
        for (int t = 1; t <= 300; t++) begin
            if (b_fs === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("fs_unexpected_t", 32'(t), 0);
                end else begin
                    fs_exp = exp_q.pop_front();
                    chk("fs_t", 32'(t), fs_exp);
                end
            end
            if (b_vs === 1'b0 && vs_first_x < 0) begin
                vs_first_x = int'(b_dx);
                vs_first_y = int'(b_dy);
            end
            if (t < 150) begin
                if (b_vs === 1'b0) vs_low1++;
                if (b_blank === 1'b1) blank1++;
            end else if (t < 300) begin
                if (b_vs === 1'b0) vs_low2++;
                if (b_blank === 1'b1) blank2++;
                if (b_hs === 1'b0) hs_low2++;
            end
            if (t == 149) begin wrap_x = b_dx; wrap_y = b_dy; end
            if (t == 150) begin
                next_x = b_dx; next_y = b_dy;
                wrap_fs = b_fs; wrap_blank = b_blank;
            end
            if (t == 232) edge_639_479 = b_blank;   // (7,5)
            if (t == 233) edge_640_479 = b_blank;   // (8,5)
            if (t == 240) edge_0_480   = b_blank;   // (0,6)
            if (t < 300) tick();
        end
        chk("fs_pending",    32'(exp_q.size()), 0);
        chk("vs_low_f1",     32'(vs_low1), 30);
        chk("vs_low_f2",     32'(vs_low2), 30);
        chk("vs_first_x",    32'(vs_first_x), SYNC_LAT);
        chk("vs_first_y",    32'(vs_first_y), 7);
        chk("blank_f1",      32'(blank1), 47);   // t=0 (inside reset) not sampled
        chk("blank_f2",      32'(blank2), 48);
        chk("hs_low_f2",     32'(hs_low2), 30);
        chk("wrap_last_x",   32'(wrap_x), 14);
        chk("wrap_last_y",   32'(wrap_y), 9);
        chk("wrap_next_x",   32'(next_x), 0);
        chk("wrap_next_y",   32'(next_y), 0);
        chk("wrap_fs",       32'(wrap_fs), 1);
        chk("wrap_blank",    32'(wrap_blank), 1);
        chk("edge_last_vis", 32'(edge_639_479), 1);
        chk("edge_h_blank",  32'(edge_640_479), 0);
        chk("edge_v_blank",  32'(edge_0_480), 0);

        // Full-size raster has kept counting since the release: t=300 -> (300,0).
        chk("a_after_dx", 32'(a_dx), 300);
        chk("a_after_dy", 32'(a_dy), 0);
        chk("a_after_fs", 32'(a_fs), 0);

        // ------------------------------------------------------------ report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
